// File: rtl/scan_chain_loader.sv
// Serial loader that shifts a parallel instruction word MSB-first into the decoder scan chain.
// Define SCAN_CHAIN_LOADER_VERIFY_EN to add a second, self-checking verify pass.
module scan_chain_loader #(
    parameter int WORD_W = 16
) (
    input  logic              clk,
    input  logic              global_reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] load_word,
    input  logic              abort,
    input  logic              scan_out,
    output logic              scan_en,
    output logic              scan_in,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic [WORD_W-1:0] readback,
    output logic              verify_err
);

    localparam int CNT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WORD_W - 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SHIFT  = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;
`ifdef SCAN_CHAIN_LOADER_VERIFY_EN
    localparam logic [1:0] ST_VERIFY = 2'd3;
`endif

    logic [1:0]        state_q, state_d;
    logic [WORD_W-1:0] sh_q, sh_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WORD_W-1:0] readback_q, readback_d;
    logic              scan_en_q, scan_en_d;
    logic              scan_in_q, scan_in_d;
    logic              done_q, done_d;
    logic              aborted_q, aborted_d;
`ifdef SCAN_CHAIN_LOADER_VERIFY_EN
    logic [WORD_W-1:0] word_q, word_d;
    logic              verify_err_q, verify_err_d;
`endif

    always_comb begin
        state_d    = state_q;
        sh_d       = sh_q;
        cnt_d      = cnt_q;
        readback_d = readback_q;
        aborted_d  = 1'b0;
`ifdef SCAN_CHAIN_LOADER_VERIFY_EN
        word_d       = word_q;
        verify_err_d = verify_err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    sh_d    = load_word;
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
`ifdef SCAN_CHAIN_LOADER_VERIFY_EN
                    word_d  = load_word;
`endif
                end
            end
`ifdef SCAN_CHAIN_LOADER_VERIFY_EN
            ST_SHIFT, ST_VERIFY: begin
`else
            ST_SHIFT: begin
`endif
                sh_d       = {sh_q[WORD_W-2:0], 1'b0};
                readback_d = {readback_q[WORD_W-2:0], scan_out};
                cnt_d      = cnt_q + 1'b1;
                // abort wins over the final-count transition
                if (abort) begin
                    state_d   = ST_IDLE;
                    aborted_d = 1'b1;
                end else if (cnt_q == LAST_CNT) begin
`ifdef SCAN_CHAIN_LOADER_VERIFY_EN
                    if (state_q == ST_SHIFT) begin
                        // second pass reloads the word with no scan_en gap
                        state_d = ST_VERIFY;
                        sh_d    = word_q;
                        cnt_d   = '0;
                    end else begin
                        state_d = ST_DONE;
                        if (readback_d != {word_q[WORD_W-2:0], word_q[WORD_W-1]})
                            verify_err_d = 1'b1;
                    end
`else
                    state_d = ST_DONE;
`endif
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

`ifdef SCAN_CHAIN_LOADER_VERIFY_EN
        scan_en_d = (state_d == ST_SHIFT) || (state_d == ST_VERIFY);
`else
        scan_en_d = (state_d == ST_SHIFT);
`endif
        scan_in_d = scan_en_d & sh_d[WORD_W-1];
        done_d    = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge global_reset_n) begin
        if (!global_reset_n) begin
            state_q    <= ST_IDLE;
            sh_q       <= '0;
            cnt_q      <= '0;
            readback_q <= '0;
            scan_en_q  <= 1'b0;
            scan_in_q  <= 1'b0;
            done_q     <= 1'b0;
            aborted_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            sh_q       <= sh_d;
            cnt_q      <= cnt_d;
            readback_q <= readback_d;
            scan_en_q  <= scan_en_d;
            scan_in_q  <= scan_in_d;
            done_q     <= done_d;
            aborted_q  <= aborted_d;
        end
    end

`ifdef SCAN_CHAIN_LOADER_VERIFY_EN
    always_ff @(posedge clk or negedge global_reset_n) begin
        if (!global_reset_n) begin
            word_q       <= '0;
            verify_err_q <= 1'b0;
        end else begin
            word_q       <= word_d;
            verify_err_q <= verify_err_d;
        end
    end

    assign verify_err = verify_err_q;
`else
    assign verify_err = 1'b0;
`endif

    assign in_ready = (state_q == ST_IDLE);
    assign busy     = scan_en_q;
    assign scan_en  = scan_en_q;
    assign scan_in  = scan_in_q;
    assign done     = done_q;
    assign aborted  = aborted_q;
    assign readback = readback_q;

endmodule

// File: doc/scan_chain_loader.md
Name: scan_chain_loader

Overview:
- Serial instruction loader that drives the decoder's scan chain (scan_en / scan_in) and captures the decoder's scan_out for readback.
- Accepts a parallel instruction word over a valid/ready handshake, then shifts it MSB-first into the decoder's instruction register.
- Used by the test/boot controller to force instructions into the datapath without instruction memory.

Parameters:
- WORD_W, 16, instruction word width and number of shift cycles per pass.

Ports:
- clk  input  1  system clock; all state changes on its rising edge
- global_reset_n  input  1  asynchronous active-low reset
- in_valid  input  1  load_word is valid
- in_ready  output  1  loader can accept a word; equals (state==IDLE)
- load_word  input  WORD_W  instruction to shift in
- abort  input  1  cancel an in-progress shift
- scan_out  input  1  decoder scan_out, sampled every shift cycle
- scan_en  output  1  decoder scan enable, registered
- scan_in  output  1  decoder serial data, registered (shift register MSB)
- busy  output  1  high in SHIFT (and VERIFY) states
- done  output  1  one-cycle pulse: word fully loaded, readback valid
- aborted  output  1  one-cycle pulse: shift cancelled by abort
- readback  output  WORD_W  bits captured from scan_out, MSB-first
- verify_err  output  1  sticky mismatch flag (optional feature only; tied 0 otherwise)

Behaviour:
- Reset (global_reset_n low, asynchronous): state=IDLE, scan_en=0, scan_in=0, busy=0, done=0, aborted=0, readback=0, verify_err=0, bit counter=0. in_ready=1 while in IDLE, including during reset.
- FSM states: IDLE, SHIFT, VERIFY (optional feature only), DONE.
- IDLE: if in_valid && in_ready at an edge, latch load_word into shift register sh, set bit counter=0, go to SHIFT. Otherwise stay.
- SHIFT: scan_en=1 and scan_in=sh[WORD_W-1] throughout the state. At each edge: sh shifts left by 1; readback shifts left with scan_out entering bit 0; counter increments.
  - Edge with counter==WORD_W-1: go to DONE (or VERIFY; see optional feature).
  - Exactly WORD_W cycles with scan_en=1 per pass; never WORD_W+1.
- DONE: scan_en=0, done=1 for exactly one cycle, then IDLE. readback holds until the next DONE.
- Latency: accept edge to done = WORD_W+1 cycles. Minimum accept-to-accept spacing = WORD_W+2 cycles.
- in_valid is ignored outside IDLE. load_word is not re-sampled after accept.
- abort:
  - Sampled only in SHIFT/VERIFY. An abort at an edge goes to IDLE, drops scan_en the next cycle, pulses aborted once, and produces no done. readback keeps its partial contents.
  - abort in IDLE/DONE has no effect. abort has priority over the final-count transition.
- Expected decoder readback after one pass: readback = {old_instr_reg[14:0], load_word[15]}, because decoder scan_out equals its instr_reg[14] during scan.
- Mid-operation reset: all state clears asynchronously. scan_en drops immediately.

Optional Feature:
- Macro: SCAN_CHAIN_LOADER_VERIFY_EN.
- Defined:
  - After the first pass, enter VERIFY and shift the same word a second time (sh reloaded from the latched word) with scan_en held continuously high: 2*WORD_W scan cycles, no gap.
  - Second-pass readback must equal {load_word[WORD_W-2:0], load_word[WORD_W-1]}. On mismatch, set verify_err, which stays set until reset.
  - done asserts after VERIFY; latency becomes 2*WORD_W+1.
- Undefined: no VERIFY state. verify_err tied 0. Single pass only.

Test Plan:
- Reset then in_valid=1, load_word=16'h5A3C -> scan_en high exactly 16 cycles; scan_in sequence 0,1,0,1,1,0,1,0,0,0,1,1,1,1,0,0; done pulses at cycle 17; decoder instr_reg=16'h5A3C.
- Decoder instr_reg preloaded 16'hFFFF, load 16'h0000 -> readback=16'hFFFE.
- Abort asserted on the 5th SHIFT cycle of load 16'h1234 -> aborted pulse, no done, scan_en low the next cycle, in_ready=1.
- in_valid held high with words 16'hAAAA then 16'h5555 -> second accept exactly 18 cycles after the first; two done pulses.
- global_reset_n pulsed low during SHIFT cycle 8 -> scan_en=0 asynchronously, all outputs 0, in_ready=1 after release.
- SCAN_CHAIN_LOADER_VERIFY_EN defined, load 16'h8001 -> 32 consecutive scan_en cycles, readback=16'h0003, verify_err=0. Forcing scan_out stuck 0 -> verify_err=1.
